// File: rtl/aes_key_sched_ctrl_if.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_sched_ctrl_if
//  Brief    : Stream bundle between the host, the key-schedule sequencer and
//             the AES round datapath.
//             in_*  : host -> sequencer packets (valid/ready)
//             out_* : sequencer -> datapath blocks (valid/ready)
//             Modport slave is the sequencer side, master the host/datapath.
//  Revision : 1.0  initial release
// ============================================================================
interface aes_key_sched_ctrl_if #(
   parameter int DW = 128
);
   logic          in_valid;
   logic          in_ready;
   logic [DW-1:0] in_data;
   logic          in_en_de;
   logic          in_set_key;
   logic          out_valid;
   logic          out_ready;
   logic [DW-1:0] out_data;
   logic          out_en_de;

   modport slave (
      input  in_valid, in_data, in_en_de, in_set_key, out_ready,
      output in_ready, out_valid, out_data, out_en_de
   );

   modport master (
      output in_valid, in_data, in_en_de, in_set_key, out_ready,
      input  in_ready, out_valid, out_data, out_en_de
   );
endinterface
`default_nettype wire

// File: rtl/aes_key_sched_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : aes_key_sched_ctrl
//  Brief    : Sequencer between the host packet stream and the AES round
//             datapath. Key-load packets wait for the datapath to drain, then
//             are walked through an external one-round key-expansion unit,
//             writing NR+1 round keys into the round-key file, one per cycle.
//             Data packets are forwarded through a one-entry output buffer
//             only while a complete key set is loaded; otherwise dropped
//             with an err_nokey pulse.
//  Ports    : clk, rst (async, active-high)
//             bus        - host in_* / datapath out_* streams (slave modport)
//             pipe_idle  - datapath has no blocks in flight
//             exp_key_o, exp_rcon_o / exp_key_i - expansion unit link
//             key_out, set_key - round-key file write port (one-hot strobe)
//             busy, key_valid, err_nokey - status
//  Options  : AES_KEY_ZEROIZE_EN - key packet with in_en_de=1 wipes the
//             round-key file (all strobes, zero data) instead of expanding.
//  Revision : 1.0  initial release
// ============================================================================
module aes_key_sched_ctrl #(
   parameter int NR = 10,
   parameter int DW = 128
) (
   input  logic                 clk,
   input  logic                 rst,
   aes_key_sched_ctrl_if.slave  bus,
   input  logic                 pipe_idle,
   output logic [DW-1:0]        exp_key_o,
   output logic [7:0]           exp_rcon_o,
   input  logic [DW-1:0]        exp_key_i,
   output logic [DW-1:0]        key_out,
   output logic [NR:0]          set_key,
   output logic                 busy,
   output logic                 key_valid,
   output logic                 err_nokey
);

   localparam int                c_RW       = $clog2(NR + 1);
   localparam logic [c_RW-1:0]   c_RND_LAST = c_RW'(NR);
   localparam logic [c_RW-1:0]   c_RND_ONE  = c_RW'(1);
   localparam logic [NR:0]       c_SK_ONE   = (NR+1)'(1);

   typedef enum logic [1:0] {
      S_IDLE       = 2'd0,
      S_WAIT_DRAIN = 2'd1,
      S_EXPAND     = 2'd2,
      S_ZEROIZE    = 2'd3
   } state_t;

   state_t            r_state;
   logic [c_RW-1:0]   r_rnd;
   logic [DW-1:0]     r_wkey;
   logic              r_key_valid;
   logic              r_out_valid;
   logic [DW-1:0]     r_out_data;
   logic              r_out_en_de;
   logic              r_err_nokey;

   logic              w_in_ready;
   logic              w_in_fire;
   logic              w_rnd_nz;

   // xtime in GF(2^8); repeated doubling from 01 yields the AES round constants
   function automatic logic [7:0] f_xtime(input logic [7:0] a);
      return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
   endfunction

   function automatic logic [7:0] f_rcon(input logic [c_RW-1:0] r);
      logic [7:0] v;
      v = 8'h01;
      for (int i = 2; i <= NR; i++) begin
         if (i <= int'(r)) v = f_xtime(v);
      end
      return (r == '0) ? 8'h00 : v;
   endfunction

   // Key packets additionally need an empty buffer so a key change can never
   // overtake a block already handed to the output stage.
   always_comb begin
      w_in_ready = 1'b0;
      if (!rst && r_state == S_IDLE) begin
         if (bus.in_set_key) w_in_ready = !r_out_valid;
         else                w_in_ready = !r_out_valid || bus.out_ready;
      end
   end

   assign w_in_fire = bus.in_valid && w_in_ready;

   // Round-key write port is decoded from registered state so that the
   // combinational expansion result can be written in the same cycle.
   always_comb begin
      w_rnd_nz   = (r_state == S_EXPAND) && (r_rnd != '0);
      exp_key_o  = w_rnd_nz ? r_wkey : '0;
      exp_rcon_o = w_rnd_nz ? f_rcon(r_rnd) : 8'h00;
      key_out    = '0;
      set_key    = '0;
      if (r_state == S_EXPAND) begin
         key_out = w_rnd_nz ? exp_key_i : r_wkey;
         set_key = c_SK_ONE << r_rnd;
      end
`ifdef AES_KEY_ZEROIZE_EN
      if (r_state == S_ZEROIZE) set_key = '1;
`endif
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_rnd       <= '0;
         r_wkey      <= '0;
         r_key_valid <= 1'b0;
         r_out_valid <= 1'b0;
         r_out_data  <= '0;
         r_out_en_de <= 1'b0;
         r_err_nokey <= 1'b0;
      end else begin
         r_err_nokey <= 1'b0;
         if (r_out_valid && bus.out_ready) r_out_valid <= 1'b0;

         case (r_state)
            S_IDLE: begin
               if (w_in_fire) begin
                  if (bus.in_set_key) begin
                     r_key_valid <= 1'b0;
`ifdef AES_KEY_ZEROIZE_EN
                     if (bus.in_en_de) begin
                        r_wkey  <= '0;
                        r_state <= S_ZEROIZE;
                     end else begin
                        r_wkey  <= bus.in_data;
                        r_state <= S_WAIT_DRAIN;
                     end
`else
                     r_wkey  <= bus.in_data;
                     r_state <= S_WAIT_DRAIN;
`endif
                  end else if (r_key_valid) begin
                     // Refill wins over the handshake clear above.
                     r_out_valid <= 1'b1;
                     r_out_data  <= bus.in_data;
                     r_out_en_de <= bus.in_en_de;
                  end else begin
                     r_err_nokey <= 1'b1;
                  end
               end
            end

            S_WAIT_DRAIN: begin
               if (pipe_idle) begin
                  r_rnd   <= '0;
                  r_state <= S_EXPAND;
               end
            end

            S_EXPAND: begin
               if (r_rnd != '0) r_wkey <= exp_key_i;
               if (r_rnd == c_RND_LAST) begin
                  r_rnd       <= '0;
                  r_key_valid <= 1'b1;
                  r_state     <= S_IDLE;
               end else begin
                  r_rnd <= r_rnd + c_RND_ONE;
               end
            end

            // Zeroize cycle: strobes all entries once, then back to idle.
            default: r_state <= S_IDLE;
         endcase
      end
   end

   assign bus.in_ready  = w_in_ready;
   assign bus.out_valid = r_out_valid;
   assign bus.out_data  = r_out_data;
   assign bus.out_en_de = r_out_en_de;
   assign busy          = (r_state != S_IDLE);
   assign key_valid     = r_key_valid;
   assign err_nokey     = r_err_nokey;

endmodule
`default_nettype wire
